byte_unstrip_ctrl: RTL and testbench
====================================

Name: byte_unstrip_ctrl

Overview:
- Sequencing controller for the receive-side byte unstriping path.
- Accepts one parallel word per handshake from up to four lanes (LANE0..3, DK_0..3).
- Acquires lane alignment on a COM symbol (K28.5), then serialises the active lanes lane0-first onto a single byte stream with valid/ready flow control.
- Replaces free-running lane rotation with a deterministic, backpressure-aware scheduler.

Parameters:
COM_SYM, 8'hBC, alignment symbol value (valid only with DK=1)
MODE_RESET, 2'b10, lane mode applied at reset (x4)

Ports:
CLK  input  1  single clock, all logic on rising edge
RESET  input  1  synchronous, active-high reset
LANE_MODE  input  2  00=x1 (lane0), 01=x2 (lanes0-1), 10=x4, 11=reserved, treated as x4
LANE0..LANE3  input  8 each  lane data bytes
DK_0..DK_3  input  1 each  control-symbol flag per lane
LANES_VALID  input  1  parallel lane word present
LANES_READY  output  1  controller accepts lane word this cycle (combinational)
D  output  8  serialised byte
DK  output  1  control flag for D
D_VALID  output  1  D/DK valid
D_READY  input  1  downstream accepts D
LANE_SEL  output  2  lane index of byte currently on D
ALIGNED  output  1  alignment acquired
ALIGN_ERR  output  1  one-cycle pulse on alignment loss

Behaviour:
- Reset is synchronous; it overrides every other event, including reset mid-drain.
  - State returns to UNALIGNED; the holding register is cleared.
  - D=0, DK=0, D_VALID=0, LANE_SEL=0, ALIGNED=0, ALIGN_ERR=0.
  - Active mode register loads MODE_RESET.
- N = active lane count: 1, 2 or 4.
- Word accepted = LANES_VALID && LANES_READY.
- COM-all: every active lane = COM_SYM with DK=1.
- COM-partial: at least one active lane, but not all, is COM with DK=1.
- Inactive lanes are ignored in every check.

UNALIGNED state:
- LANES_READY=1; all words are consumed and none is emitted.
- Active mode register samples LANE_MODE on every accepted word.
- Accepted COM-all word: go to LOAD; ALIGNED=1 from the next cycle.

LOAD state:
- LANES_READY=1, D_VALID=0.
- Accepted COM-all word: dropped (skip/realign); stay in LOAD.
- Accepted COM-partial word: dropped; ALIGN_ERR=1 for the next cycle, ALIGNED=0, go to UNALIGNED.
- Any other accepted word: active lanes captured into the holding register; LANE_SEL=0; D_VALID=1 from the next cycle; go to DRAIN.

DRAIN state:
- D/DK = holding[LANE_SEL] and stay stable while D_VALID && !D_READY.
- Handshake with LANE_SEL < N-1: LANE_SEL increments.
- LANES_READY = D_READY && LANE_SEL==N-1. This allows back-to-back words with no bubble, giving x4 a sustained 1 byte/cycle.
- Last-byte handshake with a word accepted:
  - COM-all, COM-partial or data word: same treatment as in LOAD.
  - COM-all or COM-partial also drops D_VALID next cycle.
  - Data word reloads, sets LANE_SEL=0 and keeps D_VALID=1.
- Last-byte handshake with no word accepted: go to LOAD; D_VALID=0.

General rules:
- Latency: accepted data word to first byte on D = 1 cycle.
- LANE_MODE changes while ALIGNED are ignored until the next realignment.
- DK is passed through unchanged for non-COM control symbols.
- ALIGN_ERR is never asserted in UNALIGNED.

Test Plan:
- Alignment in x4: reset; word {BC,BC,BC,BC} with DK=1111, then {11,22,33,44} DK=0000, D_READY=1 -> ALIGNED=1; D=11,22,33,44 on 4 consecutive cycles; LANE_SEL 0..3; COM never emitted.
- Backpressure in x4: D_READY low on the cycle D=22 -> D holds 22 and LANE_SEL=1; LANES_READY=0 until the cycle LANE_SEL=3 with D_READY=1.
- x2 back-to-back: LANE_MODE=01, align, words {A1,A2,xx,xx} and {B1,B2,xx,xx} held valid -> D=A1,A2,B1,B2 with no bubble; lanes 2-3 ignored.
- Alignment loss: aligned x4, word {BC,00,BC,00} DK=1010 -> ALIGN_ERR high exactly 1 cycle, ALIGNED=0; following data words not emitted until a COM-all word.
- Skip plus mid-drain reset: COM-all while aligned -> dropped, ALIGNED stays 1. Then RESET asserted at LANE_SEL=2 -> next cycle D_VALID=0, D=0, LANE_SEL=0, ALIGNED=0.

Source files
------------

// File: rtl/byte_unstrip_ctrl.sv
// Receive-side byte unstriping controller: aligns up to four lanes on a COM
// word and serialises the active lanes lane0-first onto a valid/ready byte stream.
module byte_unstrip_ctrl #(
  parameter logic [7:0] COM_SYM    = 8'hBC,
  parameter logic [1:0] MODE_RESET = 2'b10
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] LANE_MODE,
  input  logic [7:0] LANE0,
  input  logic [7:0] LANE1,
  input  logic [7:0] LANE2,
  input  logic [7:0] LANE3,
  input  logic       DK_0,
  input  logic       DK_1,
  input  logic       DK_2,
  input  logic       DK_3,
  input  logic       LANES_VALID,
  output logic       LANES_READY,
  output logic [7:0] D,
  output logic       DK,
  output logic       D_VALID,
  input  logic       D_READY,
  output logic [1:0] LANE_SEL,
  output logic       ALIGNED,
  output logic       ALIGN_ERR,
  output logic [1:0] dbg_state
);

  // Handshakes: a lane word transfers when LANES_VALID && LANES_READY on a
  // rising edge; a byte transfers when D_VALID && D_READY. D/DK/LANE_SEL hold
  // steady while D_VALID is high and D_READY is low.

  typedef enum logic [1:0] {
    S_UNALIGNED = 2'd0,
    S_LOAD      = 2'd1,
    S_DRAIN     = 2'd2
  } state_t;

  state_t          state;
  logic [1:0]      mode_q;
  logic [1:0]      eff_mode;
  logic [1:0]      last_sel;
  logic [1:0]      sel_q;
  logic            d_valid_q;
  logic            aligned_q;
  logic            align_err_q;
  logic [3:0][7:0] hold;
  logic [3:0]      hold_dk;

  logic [3:0][7:0] lane;
  logic [3:0]      lane_dk;
  logic [3:0]      active;
  logic [3:0]      is_com;
  logic [3:0][7:0] cap_data;
  logic [3:0]      cap_dk;
  logic            com_all;
  logic            com_part;
  logic            lanes_ready;
  logic            accept;

  // While unaligned the word being checked is also the one whose mode is
  // latched, so qualify it with the live LANE_MODE.
  always_comb begin
    lane     = {LANE3, LANE2, LANE1, LANE0};
    lane_dk  = {DK_3, DK_2, DK_1, DK_0};
    eff_mode = (state == S_UNALIGNED) ? LANE_MODE : mode_q;
    active   = 4'b1111;
    last_sel = 2'd3;
    case (eff_mode)
      2'b00: begin
        active   = 4'b0001;
        last_sel = 2'd0;
      end
      2'b01: begin
        active   = 4'b0011;
        last_sel = 2'd1;
      end
      default: begin
        active   = 4'b1111;
        last_sel = 2'd3;
      end
    endcase
  end

  always_comb begin
    is_com   = '0;
    cap_data = '0;
    cap_dk   = '0;
    for (int i = 0; i < 4; i++) begin
      is_com[i]   = lane_dk[i] && (lane[i] == COM_SYM);
      cap_data[i] = active[i] ? lane[i] : 8'h00;
      cap_dk[i]   = active[i] && lane_dk[i];
    end
    com_all  = ((is_com & active) == active);
    com_part = (|(is_com & active)) && !com_all;
  end

  // Ready on the last byte handshake lets the next word reload without a bubble.
  always_comb begin
    lanes_ready = (state != S_DRAIN) || (D_READY && (sel_q == last_sel));
    accept      = LANES_VALID && lanes_ready;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_UNALIGNED;
      mode_q      <= MODE_RESET;
      sel_q       <= 2'd0;
      d_valid_q   <= 1'b0;
      aligned_q   <= 1'b0;
      align_err_q <= 1'b0;
      hold        <= '0;
      hold_dk     <= '0;
    end else begin
      align_err_q <= 1'b0;
      case (state)
        S_UNALIGNED: begin
          if (accept) begin
            mode_q <= LANE_MODE;
            if (com_all) begin
              state     <= S_LOAD;
              aligned_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (com_part) begin
              state       <= S_UNALIGNED;
              aligned_q   <= 1'b0;
              align_err_q <= 1'b1;
            end else if (!com_all) begin
              hold      <= cap_data;
              hold_dk   <= cap_dk;
              sel_q     <= 2'd0;
              d_valid_q <= 1'b1;
              state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (D_READY) begin
            if (sel_q != last_sel) begin
              sel_q <= sel_q + 2'd1;
            end else if (accept) begin
              if (com_part) begin
                state       <= S_UNALIGNED;
                aligned_q   <= 1'b0;
                align_err_q <= 1'b1;
                d_valid_q   <= 1'b0;
              end else if (com_all) begin
                state     <= S_LOAD;
                d_valid_q <= 1'b0;
              end else begin
                hold    <= cap_data;
                hold_dk <= cap_dk;
                sel_q   <= 2'd0;
              end
            end else begin
              state     <= S_LOAD;
              d_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state     <= S_UNALIGNED;
          aligned_q <= 1'b0;
          d_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign LANES_READY = lanes_ready;
  assign D           = hold[sel_q];
  assign DK          = hold_dk[sel_q];
  assign D_VALID     = d_valid_q;
  assign LANE_SEL    = sel_q;
  assign ALIGNED     = aligned_q;
  assign ALIGN_ERR   = align_err_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_byte_unstrip_ctrl.sv
// Directed bench for byte_unstrip_ctrl: a per-cycle vector table for x4/x2
// alignment, backpressure and loss, plus a hand-driven x1 sequence.
module tb_byte_unstrip_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] lane_mode;
  logic [7:0] lane0, lane1, lane2, lane3;
  logic       dk_0, dk_1, dk_2, dk_3;
  logic       lanes_valid;
  logic       lanes_ready;
  logic [7:0] d;
  logic       dk;
  logic       d_valid;
  logic       d_ready;
  logic [1:0] lane_sel;
  logic       aligned;
  logic       align_err;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  byte_unstrip_ctrl dut (
    .CLK(clk), .RESET(rst), .LANE_MODE(lane_mode),
    .LANE0(lane0), .LANE1(lane1), .LANE2(lane2), .LANE3(lane3),
    .DK_0(dk_0), .DK_1(dk_1), .DK_2(dk_2), .DK_3(dk_3),
    .LANES_VALID(lanes_valid), .LANES_READY(lanes_ready),
    .D(d), .DK(dk), .D_VALID(d_valid), .D_READY(d_ready),
    .LANE_SEL(lane_sel), .ALIGNED(aligned), .ALIGN_ERR(align_err),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  mode;
    logic [31:0] lanes;
    logic [3:0]  dk;
    logic        lv;
    logic        dr;
    logic        lr;
    logic [7:0]  d;
    logic        dko;
    logic        dv;
    logic [1:0]  sel;
    logic        al;
    logic        err;
    logic        chk_d;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic add(input logic r, input logic [1:0] m, input logic [31:0] ln,
                     input logic [3:0] k, input logic lv, input logic dr,
                     input logic lr, input logic [7:0] dd, input logic dko,
                     input logic dv, input logic [1:0] sel, input logic al,
                     input logic err, input logic chk_d);
    vec_t v;
    v.rst = r; v.mode = m; v.lanes = ln; v.dk = k; v.lv = lv; v.dr = dr;
    v.lr = lr; v.d = dd; v.dko = dko; v.dv = dv; v.sel = sel; v.al = al;
    v.err = err; v.chk_d = chk_d;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [1:0] m, input logic [31:0] ln,
                       input logic [3:0] k, input logic lv, input logic dr);
    rst         = r;
    lane_mode   = m;
    lane0       = ln[7:0];
    lane1       = ln[15:8];
    lane2       = ln[23:16];
    lane3       = ln[31:24];
    dk_0        = k[0];
    dk_1        = k[1];
    dk_2        = k[2];
    dk_3        = k[3];
    lanes_valid = lv;
    d_ready     = dr;
  endtask

  task automatic cmp(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, want);
    end
  endtask

  // Scoreboard: every byte handshake must match the head of exp_q.
  task automatic mon(input int idx);
    logic [7:0] e;
    if (d_valid && d_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_extra[%0d]: got %0h expected no byte", idx, d);
      end else begin
        e = exp_q.pop_front();
        cmp("sb_byte", idx, d, e);
        cmp("sb_sel", idx, {6'd0, lane_sel}, 8'd0);
      end
    end
  endtask

  initial begin
    // x4 alignment then one data word
    add(0, 2'd2, 32'h00000000, 4'h0, 0, 1,  1, 8'h00, 0, 0, 2'd0, 0, 0, 1);
    add(0, 2'd2, 32'hBCBCBCBC, 4'hF, 1, 1,  1, 8'h00, 0, 0, 2'd0, 0, 0, 1);
    add(0, 2'd2, 32'h44332211, 4'h0, 1, 1,  1, 8'h00, 0, 0, 2'd0, 1, 0, 0);
    add(0, 2'd2, 32'h00000000, 4'h0, 0, 1,  0, 8'h11, 0, 1, 2'd0, 1, 0, 1);
    add(0, 2'd2, 32'h00000000, 4'h0, 0, 1,  0, 8'h22, 0, 1, 2'd1, 1, 0, 1);
    add(0, 2'd2, 32'h00000000, 4'h0, 0, 1,  0, 8'h33, 0, 1, 2'd2, 1, 0, 1);
    add(0, 2'd2, 32'h00000000, 4'h0, 0, 1,  1, 8'h44, 0, 1, 2'd3, 1, 0, 1);
    add(0, 2'd2, 32'h00000000, 4'h0, 0, 1,  1, 8'h00, 0, 0, 2'd0, 1, 0, 0);
    // x4 backpressure with the next word waiting
    add(0, 2'd2, 32'h44332211, 4'h0, 1, 1,  1, 8'h00, 0, 0, 2'd0, 1, 0, 0);
    add(0, 2'd2, 32'hCCBBAA99, 4'h0, 1, 1,  0, 8'h11, 0, 1, 2'd0, 1, 0, 1);
    add(0, 2'd2, 32'hCCBBAA99, 4'h0, 1, 0,  0, 8'h22, 0, 1, 2'd1, 1, 0, 1);
    add(0, 2'd2, 32'hCCBBAA99, 4'h0, 1, 0,  0, 8'h22, 0, 1, 2'd1, 1, 0, 1);
    add(0, 2'd2, 32'hCCBBAA99, 4'h0, 1, 1,  0, 8'h22, 0, 1, 2'd1, 1, 0, 1);
    add(0, 2'd2, 32'hCCBBAA99, 4'h0, 1, 1,  0, 8'h33, 0, 1, 2'd2, 1, 0, 1);
    add(0, 2'd2, 32'hCCBBAA99, 4'h0, 1, 0,  0, 8'h44, 0, 1, 2'd3, 1, 0, 1);
    add(0, 2'd2, 32'hCCBBAA99, 4'h0, 1, 1,  1, 8'h44, 0, 1, 2'd3, 1, 0, 1);
    add(0, 2'd2, 32'h00000000, 4'h0, 0, 1,  0, 8'h99, 0, 1, 2'd0, 1, 0, 1);
    add(0, 2'd2, 32'h00000000, 4'h0, 0, 1,  0, 8'hAA, 0, 1, 2'd1, 1, 0, 1);
    add(0, 2'd2, 32'h00000000, 4'h0, 0, 1,  0, 8'hBB, 0, 1, 2'd2, 1, 0, 1);
    add(0, 2'd2, 32'h00000000, 4'h0, 0, 1,  1, 8'hCC, 0, 1, 2'd3, 1, 0, 1);
    add(0, 2'd2, 32'h00000000, 4'h0, 0, 1,  1, 8'h00, 0, 0, 2'd0, 1, 0, 0);
    // partial COM: loss, data swallowed until COM-all, then skip in DRAIN/LOAD
    add(0, 2'd2, 32'h00BC00BC, 4'h5, 1, 1,  1, 8'h00, 0, 0, 2'd0, 1, 0, 0);
    add(0, 2'd2, 32'h44332211, 4'h0, 1, 1,  1, 8'h00, 0, 0, 2'd0, 0, 1, 0);
    add(0, 2'd2, 32'h88776655, 4'h0, 1, 1,  1, 8'h00, 0, 0, 2'd0, 0, 0, 0);
    add(0, 2'd2, 32'hBCBCBCBC, 4'hF, 1, 1,  1, 8'h00, 0, 0, 2'd0, 0, 0, 0);
    add(0, 2'd2, 32'h04030201, 4'h0, 1, 1,  1, 8'h00, 0, 0, 2'd0, 1, 0, 0);
    add(0, 2'd2, 32'h00000000, 4'h0, 0, 1,  0, 8'h01, 0, 1, 2'd0, 1, 0, 1);
    add(0, 2'd2, 32'h00000000, 4'h0, 0, 1,  0, 8'h02, 0, 1, 2'd1, 1, 0, 1);
    add(0, 2'd2, 32'h00000000, 4'h0, 0, 1,  0, 8'h03, 0, 1, 2'd2, 1, 0, 1);
    add(0, 2'd2, 32'hBCBCBCBC, 4'hF, 1, 1,  1, 8'h04, 0, 1, 2'd3, 1, 0, 1);
    add(0, 2'd2, 32'hBCBCBCBC, 4'hF, 1, 1,  1, 8'h00, 0, 0, 2'd0, 1, 0, 0);
    add(0, 2'd2, 32'h00000000, 4'h0, 0, 1,  1, 8'h00, 0, 0, 2'd0, 1, 0, 0);
    // non-COM control symbols keep DK, then reset mid-drain at LANE_SEL=2
    add(0, 2'd2, 32'h34FC12F7, 4'h5, 1, 1,  1, 8'h00, 0, 0, 2'd0, 1, 0, 0);
    add(0, 2'd2, 32'h00000000, 4'h0, 0, 1,  0, 8'hF7, 1, 1, 2'd0, 1, 0, 1);
    add(0, 2'd2, 32'h00000000, 4'h0, 0, 1,  0, 8'h12, 0, 1, 2'd1, 1, 0, 1);
    add(1, 2'd2, 32'h00000000, 4'h0, 0, 1,  0, 8'hFC, 1, 1, 2'd2, 1, 0, 1);
    add(0, 2'd2, 32'h00000000, 4'h0, 0, 1,  1, 8'h00, 0, 0, 2'd0, 0, 0, 1);
    // x2 back-to-back, inactive lanes ignored, mode change while aligned ignored
    add(0, 2'd1, 32'h0000BCBC, 4'h3, 1, 1,  1, 8'h00, 0, 0, 2'd0, 0, 0, 0);
    add(0, 2'd1, 32'hBC5AA2A1, 4'h8, 1, 1,  1, 8'h00, 0, 0, 2'd0, 1, 0, 0);
    add(0, 2'd1, 32'hC4C3B2B1, 4'h0, 1, 1,  0, 8'hA1, 0, 1, 2'd0, 1, 0, 1);
    add(0, 2'd1, 32'hC4C3B2B1, 4'h0, 1, 1,  1, 8'hA2, 0, 1, 2'd1, 1, 0, 1);
    add(0, 2'd1, 32'h00000000, 4'h0, 0, 1,  0, 8'hB1, 0, 1, 2'd0, 1, 0, 1);
    add(0, 2'd1, 32'h00000000, 4'h0, 0, 1,  1, 8'hB2, 0, 1, 2'd1, 1, 0, 1);
    add(0, 2'd2, 32'hC4C3C2C1, 4'h0, 1, 1,  1, 8'h00, 0, 0, 2'd0, 1, 0, 0);
    add(0, 2'd2, 32'h00000000, 4'h0, 0, 1,  0, 8'hC1, 0, 1, 2'd0, 1, 0, 1);
    add(0, 2'd2, 32'h00000000, 4'h0, 0, 1,  1, 8'hC2, 0, 1, 2'd1, 1, 0, 1);
    add(0, 2'd2, 32'h00000000, 4'h0, 0, 1,  1, 8'h00, 0, 0, 2'd0, 1, 0, 0);

    // clock/reset
    drive(1, 2'd2, 32'h0, 4'h0, 0, 1);
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].mode, tbl[i].lanes, tbl[i].dk, tbl[i].lv, tbl[i].dr);
      #1;
      cmp("lanes_ready", i, {7'd0, lanes_ready}, {7'd0, tbl[i].lr});
      cmp("d_valid", i, {7'd0, d_valid}, {7'd0, tbl[i].dv});
      cmp("aligned", i, {7'd0, aligned}, {7'd0, tbl[i].al});
      cmp("align_err", i, {7'd0, align_err}, {7'd0, tbl[i].err});
      if (tbl[i].chk_d) begin
        cmp("d", i, d, tbl[i].d);
        cmp("dk", i, {7'd0, dk}, {7'd0, tbl[i].dko});
        cmp("lane_sel", i, {6'd0, lane_sel}, {6'd0, tbl[i].sel});
      end
    end

    // x1: partial COM while unaligned raises no error, then 1 byte/cycle stream
    @(negedge clk); drive(1, 2'd2, 32'h0, 4'h0, 0, 1);
    @(negedge clk); drive(0, 2'd2, 32'h00BC00BC, 4'h5, 1, 1);
    @(negedge clk); drive(0, 2'd0, 32'h332211BC, 4'h1, 1, 1);
    #1;
    cmp("x1_unal_err", 100, {7'd0, align_err}, 8'd0);
    cmp("x1_unal_aligned", 100, {7'd0, aligned}, 8'd0);
    @(negedge clk); drive(0, 2'd0, 32'h0000005E, 4'h0, 1, 1);
    #1;
    cmp("x1_aligned", 101, {7'd0, aligned}, 8'd1);
    exp_q.push_back(8'h5E);
    exp_q.push_back(8'h6F);
    exp_q.push_back(8'h7A);
    @(negedge clk); drive(0, 2'd0, 32'h0000006F, 4'h0, 1, 0);
    #1;
    cmp("x1_bp_ready", 102, {7'd0, lanes_ready}, 8'd0);
    cmp("x1_bp_d", 102, d, 8'h5E);
    mon(102);
    @(negedge clk); drive(0, 2'd0, 32'h0000006F, 4'h0, 1, 1);
    #1;
    cmp("x1_ready", 103, {7'd0, lanes_ready}, 8'd1);
    mon(103);
    @(negedge clk); drive(0, 2'd0, 32'h0000007A, 4'h0, 1, 1);
    #1;
    mon(104);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); drive(0, 2'd0, 32'h0, 4'h0, 0, 1);
      #1;
      mon(105 + c);
      if (exp_q.size() == 0) break;
    end
    cmp("sb_left", 120, exp_q.size()[7:0], 8'd0);
    @(negedge clk); drive(0, 2'd0, 32'h0, 4'h0, 0, 1);
    #1;
    cmp("x1_idle_valid", 121, {7'd0, d_valid}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
